// File: rtl/spi_result_tx.sv
// SPI slave transmit path (mode 0, MSB first) that streams the 4x4 result matrix C
// (16 x 16-bit elements, low byte first) back to the SPI master after a read command.
//
// Ports:
//   sclk        - SPI clock, the only clock of this block
//   rst_n       - asynchronous active-low reset
//   cs_n        - chip select, active-low; high holds the transaction logic in reset
//   mosi        - serial data from master, sampled on rising sclk
//   miso        - serial data to master, updated on falling sclk
//   miso_oe     - pad output enable (~cs_n)
//   res_ready   - system-domain level: result buffer valid and frozen
//   rd_addr     - element index into the result buffer (row-major)
//   rd_data     - result element at rd_addr (combinational read)
//   done_toggle - flips once per fully delivered matrix
//   state_dbg   - current FSM state
module spi_result_tx #(
  parameter logic [7:0]  CMD_READ_C = 8'h20,
  parameter logic [7:0]  STAT_READY = 8'hA5,
  parameter logic [7:0]  STAT_BUSY  = 8'h5A,
  parameter int unsigned N_ELEM     = 16
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        miso_oe,
  input  logic        res_ready,
  output logic [3:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        done_toggle,
  output logic [1:0]  state_dbg
);

  localparam logic [3:0] LastAddr = 4'(N_ELEM - 1);

  typedef enum logic [1:0] {StCmd, StStatus, StData, StDrain} state_e;

  // Transaction-scoped flops are also cleared while cs_n is high.
  logic frame_rst_n;
  assign frame_rst_n = rst_n & ~cs_n;
  assign miso_oe     = ~cs_n;

  // ---------------------------------------------------------------------------
  // Rising-edge domain: receive, bit counting, synchronizer, FSM
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  rx_shift_q, rx_shift_d;
  logic        byte_done_q, byte_done_d;
  logic        res_meta_q, res_sync_q;
  logic        done_toggle_q, done_toggle_d;

  // Falling-edge domain flops read by the FSM
  logic        stat_ok_q, last_q;

  logic        boundary;
  logic [7:0]  rx_byte;

  always_comb begin
    boundary      = (bit_cnt_q == 3'd7);
    rx_byte       = {rx_shift_q, mosi};
    bit_cnt_d     = bit_cnt_q + 3'd1;
    rx_shift_d    = {rx_shift_q[5:0], mosi};
    // Held high for the low phase after a boundary so the falling edge knows to load.
    byte_done_d   = boundary;
    state_d       = state_q;
    done_toggle_d = done_toggle_q;
    if (boundary) begin
      unique case (state_q)
        StCmd:    state_d = (rx_byte == CMD_READ_C) ? StStatus : StDrain;
        StStatus: state_d = stat_ok_q ? StData : StDrain;
        StData: begin
          if (last_q) begin
            state_d       = StDrain;
            done_toggle_d = ~done_toggle_q;
          end
        end
        StDrain:  state_d = StDrain;
      endcase
    end
  end

  always_ff @(posedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      state_q     <= StCmd;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift_q    <= 7'd0;
      res_meta_q    <= 1'b0;
      res_sync_q    <= 1'b0;
      done_toggle_q <= 1'b0;
    end else begin
      rx_shift_q    <= rx_shift_d;
      res_meta_q    <= res_ready;
      res_sync_q    <= res_meta_q;
      done_toggle_q <= done_toggle_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Falling-edge domain: byte loading, shifting, buffer addressing
  // ---------------------------------------------------------------------------
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [7:0]  hold_hi_q, hold_hi_d;
  logic        miso_q, miso_d;
  logic        hi_q, hi_d;
  logic [3:0]  rd_addr_q, rd_addr_d;
  logic        stat_ok_d, last_d;
  logic [7:0]  next_byte;

  always_comb begin
    next_byte  = 8'h00;
    tx_shift_d = {tx_shift_q[6:0], 1'b0};
    hold_hi_d  = hold_hi_q;
    hi_d       = hi_q;
    rd_addr_d  = rd_addr_q;
    stat_ok_d  = stat_ok_q;
    last_d     = last_q;
    if (byte_done_q) begin
      unique case (state_q)
        StStatus: begin
          next_byte = res_sync_q ? STAT_READY : STAT_BUSY;
          stat_ok_d = res_sync_q;
        end
        StData: begin
          if (!hi_q) begin
            // Latch the whole element now so the high byte cannot be torn.
            next_byte = rd_data[7:0];
            hold_hi_d = rd_data[15:8];
            hi_d      = 1'b1;
          end else begin
            next_byte = hold_hi_q;
            hi_d      = 1'b0;
            if (rd_addr_q == LastAddr) begin
              last_d = 1'b1;
            end else begin
              rd_addr_d = rd_addr_q + 4'd1;
            end
          end
        end
        StCmd, StDrain: next_byte = 8'h00;
      endcase
      tx_shift_d = next_byte;
    end
    // Only status and data bytes ever reach the pin; stale shift contents stay hidden.
    miso_d = ((state_q == StStatus) || (state_q == StData)) ? tx_shift_d[7] : 1'b0;
  end

  always_ff @(negedge sclk or negedge frame_rst_n) begin
    if (!frame_rst_n) begin
      miso_q    <= 1'b0;
      hi_q      <= 1'b0;
      rd_addr_q <= 4'd0;
      stat_ok_q <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      miso_q    <= miso_d;
      hi_q      <= hi_d;
      rd_addr_q <= rd_addr_d;
      stat_ok_q <= stat_ok_d;
      last_q    <= last_d;
    end
  end

  always_ff @(negedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_q <= 8'h00;
      hold_hi_q  <= 8'h00;
    end else begin
      tx_shift_q <= tx_shift_d;
      hold_hi_q  <= hold_hi_d;
    end
  end

  assign miso        = miso_q;
  assign rd_addr     = rd_addr_q;
  assign done_toggle = done_toggle_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_spi_result_tx.sv
module tb_spi_result_tx;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        mosi = 1'b0;
  logic        res_ready = 1'b0;
  logic        miso, miso_oe, done_toggle;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  state_dbg;

  logic [15:0] mem [16];
  assign rd_data = mem[rd_addr];

  int   checks = 0;
  int   errors = 0;
  logic exp_toggle = 1'b0;

  spi_result_tx dut (
    .sclk        (sclk),
    .rst_n       (rst_n),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .miso_oe     (miso_oe),
    .res_ready   (res_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .done_toggle (done_toggle),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Mode 0: master drives mosi and samples miso while sclk is low, then raises sclk.
  task automatic xfer_bit(input logic b, output logic r);
    mosi = b;
    #2;
    r = miso;
    #3 sclk = 1'b1;
    #5 sclk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
    logic [7:0] acc;
    logic       r;
    acc = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(tx[i], r);
      acc[i] = r;
    end
    rx = acc;
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    #5;
  endtask

  task automatic frame_end();
    #5 cs_n = 1'b1;
    #5;
  endtask

  // Stream byte k (k>=1 after the status byte) for buffer C[i] = 0x0100 + i, low byte first.
  function automatic logic [7:0] model_data(input int k);
    logic [15:0] v;
    if (k < 1 || k > 32) return 8'h00;
    v = 16'h0100 + 16'((k - 1) / 2);
    return ((k - 1) % 2 == 0) ? v[7:0] : v[15:8];
  endfunction

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] fill;        // mosi byte sent after the command; must be ignored
    logic       rr;          // res_ready level for the frame
    int         nbytes;      // bytes clocked after the command
    logic [7:0] exp_status;
    logic       exp_stream;  // data bytes follow the status byte
    logic       exp_flip;
    logic [3:0] exp_addr;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] rx;
    logic       r;

    for (int i = 0; i < 16; i++) mem[i] = 16'h0100 + 16'(i);

    vecs[0] = '{8'h20, 8'h00, 1'b1, 33, 8'hA5, 1'b1, 1'b1, 4'd15, 2'd3};
    vecs[1] = '{8'h20, 8'h00, 1'b0, 3,  8'h5A, 1'b0, 1'b0, 4'd0,  2'd3};
    vecs[2] = '{8'h33, 8'h00, 1'b1, 4,  8'h00, 1'b0, 1'b0, 4'd0,  2'd3};
    vecs[3] = '{8'h20, 8'h20, 1'b1, 34, 8'hA5, 1'b1, 1'b1, 4'd15, 2'd3};
    vecs[4] = '{8'h00, 8'hFF, 1'b0, 2,  8'h00, 1'b0, 1'b0, 4'd0,  2'd3};

    // Reset
    #20 rst_n = 1'b1;
    #5;
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_done_toggle", done_toggle, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_state", state_dbg, 0);

    // Table-driven frames
    for (int v = 0; v < 5; v++) begin
      res_ready = vecs[v].rr;
      frame_start();
      check($sformatf("v%0d_miso_oe", v), miso_oe, 1);
      xfer_byte(vecs[v].cmd, rx);
      check($sformatf("v%0d_cmd_byte", v), rx, 8'h00);
      for (int k = 0; k < vecs[v].nbytes; k++) begin
        xfer_byte(vecs[v].fill, rx);
        if (k == 0) check($sformatf("v%0d_status", v), rx, vecs[v].exp_status);
        else check($sformatf("v%0d_byte%0d", v, k), rx,
                   vecs[v].exp_stream ? model_data(k) : 8'h00);
      end
      if (vecs[v].exp_flip) exp_toggle = ~exp_toggle;
      check($sformatf("v%0d_done_toggle", v), done_toggle, exp_toggle);
      check($sformatf("v%0d_rd_addr", v), rd_addr, vecs[v].exp_addr);
      check($sformatf("v%0d_state", v), state_dbg, vecs[v].exp_state);
      frame_end();
      check($sformatf("v%0d_idle_oe", v), miso_oe, 0);
      check($sformatf("v%0d_idle_addr", v), rd_addr, 0);
      check($sformatf("v%0d_idle_state", v), state_dbg, 0);
      check($sformatf("v%0d_idle_miso", v), miso, 0);
    end

    // Extra sclk pulses with cs_n high have no effect
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, r);
    check("cs_high_pulses_state", state_dbg, 0);
    check("cs_high_pulses_addr", rd_addr, 0);
    check("cs_high_pulses_miso", miso, 0);
    check("cs_high_pulses_toggle", done_toggle, exp_toggle);

    // Partial command byte is discarded
    res_ready = 1'b1;
    frame_start();
    for (int i = 7; i >= 4; i--) begin
      rx = 8'h20;
      xfer_bit(rx[i], r);
    end
    frame_end();
    check("partial_cmd_state", state_dbg, 0);

    // Abort after element 5 high byte: no flip, restart at element 0
    frame_start();
    xfer_byte(8'h20, rx);
    for (int k = 0; k < 13; k++) begin
      xfer_byte(8'h00, rx);
      if (k == 0) check("abort_status", rx, 8'hA5);
      else check($sformatf("abort_byte%0d", k), rx, model_data(k));
    end
    check("abort_rd_addr", rd_addr, 6);
    check("abort_state", state_dbg, 2);
    frame_end();
    check("abort_toggle", done_toggle, exp_toggle);
    check("abort_idle_addr", rd_addr, 0);

    // Full read: element 2 rewritten mid-element, res_ready dropped during data
    frame_start();
    xfer_byte(8'h20, rx);
    for (int k = 0; k < 33; k++) begin
      xfer_byte(8'h00, rx);
      if (k == 0) check("torn_status", rx, 8'hA5);
      else check($sformatf("torn_byte%0d", k), rx, model_data(k));
      if (k == 5) mem[2] = 16'hBEEF;
      if (k == 8) res_ready = 1'b0;
    end
    exp_toggle = ~exp_toggle;
    check("torn_done_toggle", done_toggle, exp_toggle);
    check("torn_rd_addr", rd_addr, 15);
    frame_end();
    mem[2] = 16'h0102;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
